// File: rtl/program_sequencer.sv
// Instruction sequencer feeding a multicycle processor: small program store,
// one-at-a-time issue with Done handshake, mvi immediate, HALT and timeout.
module program_sequencer #(
   parameter int         ADDR_W     = 5,
   parameter logic [2:0] MVI_OPCODE = 3'b001,
   parameter int         TIMEOUT    = 15
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Load_en,
   input  logic [ADDR_W-1:0] Load_addr,
   input  logic [15:0]       Load_data,
   input  logic              Done,
   output logic [15:0]       DIN,
   output logic              Run,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Halted,
   output logic              Fault
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   logic [2:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [15:0]       mem [DEPTH];
   logic [15:0]       cur_word;
   logic [15:0]       nxt_word;
   logic [ADDR_W-1:0] pc_inc;
   logic              is_halt;
   logic              is_mvi;

   // Program store is not reset; loads only land while the sequencer is idle.
   always_ff @(posedge Clock) begin
      if (Load_en && !Busy) begin
         mem[Load_addr] <= Load_data;
      end
   end

   assign pc_inc   = PC + ADDR_W'(1);
   assign cur_word = mem[PC];
   assign nxt_word = mem[pc_inc];
   assign is_halt  = (cur_word[15:9] == 7'h7F);
   assign is_mvi   = (DIN[8:6] == MVI_OPCODE);

   assign Busy   = (state == S_FETCH) || (state == S_ISSUE) ||
                   (state == S_WAIT);
   assign Halted = (state == S_HALT);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= S_IDLE;
         DIN   <= '0;
         PC    <= '0;
         Run   <= 1'b0;
         Fault <= 1'b0;
         cnt   <= '0;
      end else begin
         Run <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (Start) begin
                  PC    <= '0;
                  Fault <= 1'b0;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (is_halt) begin
                  state <= S_HALT;
               end else begin
                  DIN   <= cur_word;
                  Run   <= 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // mvi: immediate follows on DIN during the processor's T1
               if (is_mvi) begin
                  DIN <= nxt_word;
                  PC  <= pc_inc + ADDR_W'(1);
               end else begin
                  PC  <= pc_inc;
               end
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (Done) begin
                  state <= S_FETCH;
               end else if (cnt == CNT_LAST) begin
                  Fault <= 1'b1;
                  state <= S_HALT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: scoreboard of issued words,
// timeout, wrap, busy-ignore and asynchronous reset scenarios.
module tb_program_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start1, load_en1, done1;
   logic [4:0]  load_addr1;
   logic [15:0] load_data1;
   logic [15:0] din1;
   logic        run1, busy1, halted1, fault1;
   logic [4:0]  pc1;

   logic        start2, load_en2, done2;
   logic [1:0]  load_addr2;
   logic [15:0] load_data2;
   logic [15:0] din2;
   logic        run2, busy2, halted2, fault2;
   logic [1:0]  pc2;

   int          tests = 0;
   int          fails = 0;
   int          runs1 = 0;
   int          runs2 = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_w;
   bit          found;

   program_sequencer u_dut1 (
      .Clock(clk), .Resetn(rst_n), .Start(start1),
      .Load_en(load_en1), .Load_addr(load_addr1),
      .Load_data(load_data1), .Done(done1), .DIN(din1),
      .Run(run1), .PC(pc1), .Busy(busy1), .Halted(halted1),
      .Fault(fault1)
   );

   program_sequencer #(.ADDR_W(2)) u_dut2 (
      .Clock(clk), .Resetn(rst_n), .Start(start2),
      .Load_en(load_en2), .Load_addr(load_addr2),
      .Load_data(load_data2), .Done(done2), .DIN(din2),
      .Run(run2), .PC(pc2), .Busy(busy2), .Halted(halted2),
      .Fault(fault2)
   );

   always @(posedge clk) begin
      if (run1 === 1'b1) runs1++;
      if (run2 === 1'b1) runs2++;
   end

   task automatic load(input bit w, input logic [4:0] a,
                       input logic [15:0] d);
      @(negedge clk);
      if (w) begin
         load_en2 = 1'b1; load_addr2 = a[1:0]; load_data2 = d;
      end else begin
         load_en1 = 1'b1; load_addr1 = a; load_data1 = d;
      end
      @(negedge clk);
      load_en1 = 1'b0;
      load_en2 = 1'b0;
   endtask

   task automatic start_pulse(input bit w);
      @(negedge clk);
      if (w) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_run(input bit w, output bit f);
      f = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((w ? run2 : run1) === 1'b1) begin
            f = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_halt(input bit w, output bit f);
      f = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((w ? halted2 : halted1) === 1'b1) begin
            f = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_done(input bit w, input int d);
      repeat (d) @(negedge clk);
      if (w) done2 = 1'b1; else done1 = 1'b1;
      @(negedge clk);
      done1 = 1'b0;
      done2 = 1'b0;
   endtask

   task automatic pop_exp();
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start1 = 0; load_en1 = 0; done1 = 0;
      load_addr1 = '0; load_data1 = '0;
      start2 = 0; load_en2 = 0; done2 = 0;
      load_addr2 = '0; load_data2 = '0;
      #12;
      tests++;
      if ({din1, run1, pc1, busy1, halted1, fault1} !== 25'd0) begin
         fails++;
         $display("FAIL reset1: got %h expected 0",
                  {din1, run1, pc1, busy1, halted1, fault1});
      end
      tests++;
      if ({din2, run2, pc2, busy2, halted2, fault2} !== 22'd0) begin
         fails++;
         $display("FAIL reset2: got %h expected 0",
                  {din2, run2, pc2, busy2, halted2, fault2});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_start_load();
      int r0;
      load(0, 5'd0, 16'h0008);
      r0 = runs1;
      @(negedge clk);
      load_en1 = 1'b1; load_addr1 = 5'd0; load_data1 = 16'hFE00;
      start1 = 1'b1;
      @(negedge clk);
      load_en1 = 1'b0;
      start1 = 1'b0;
      tests++;
      if (busy1 !== 1'b1) begin
         fails++;
         $display("FAIL sl_fetch: busy %b expected 1", busy1);
      end
      @(negedge clk);
      tests++;
      if ({halted1, pc1} !== {1'b1, 5'd0} || runs1 != r0) begin
         fails++;
         $display("FAIL sl_halt: halted %b pc %0d runs %0d expected 1 0 0",
                  halted1, pc1, runs1 - r0);
      end
   endtask

   task automatic test_mvi();
      int r0;
      load(0, 5'd0, 16'h0040);
      load(0, 5'd1, 16'h0005);
      load(0, 5'd2, 16'hFE00);
      r0 = runs1;
      exp_q.push_back(16'h0040);
      start_pulse(0);
      wait_run(0, found);
      pop_exp();
      tests++;
      if (!found || din1 !== exp_w || pc1 !== 5'd0) begin
         fails++;
         $display("FAIL mvi_run: found %b din %h pc %0d expected %h 0",
                  found, din1, pc1, exp_w);
      end
      @(negedge clk);
      tests++;
      if (din1 !== 16'h0005 || pc1 !== 5'd2 || run1 !== 1'b0) begin
         fails++;
         $display("FAIL mvi_imm: din %h pc %0d run %b expected 0005 2 0",
                  din1, pc1, run1);
      end
      pulse_done(0, 1);
      wait_halt(0, found);
      tests++;
      if (!found || pc1 !== 5'd2 || runs1 - r0 != 1 || busy1 !== 1'b0) begin
         fails++;
         $display("FAIL mvi_halt: found %b pc %0d runs %0d expected 2 1",
                  found, pc1, runs1 - r0);
      end
   endtask

   task automatic test_sequence();
      int r0;
      int dl [3] = '{1, 3, 6};
      logic [15:0] prog [4] = '{16'h0008, 16'h0081, 16'h00C2, 16'hFE00};
      for (int i = 0; i < 4; i++) load(0, 5'(i), prog[i]);
      for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
      r0 = runs1;
      start_pulse(0);
      for (int i = 0; i < 3; i++) begin
         wait_run(0, found);
         pop_exp();
         tests++;
         if (!found || din1 !== exp_w) begin
            fails++;
            $display("FAIL seq_din%0d: found %b din %h expected %h",
                     i, found, din1, exp_w);
         end
         @(negedge clk);
         tests++;
         if (pc1 !== 5'(i + 1)) begin
            fails++;
            $display("FAIL seq_pc%0d: pc %0d expected %0d", i, pc1, i + 1);
         end
         pulse_done(0, dl[i] - 1);
      end
      wait_halt(0, found);
      tests++;
      if (!found || pc1 !== 5'd3 || runs1 - r0 != 3) begin
         fails++;
         $display("FAIL seq_end: found %b pc %0d runs %0d expected 3 3",
                  found, pc1, runs1 - r0);
      end
   endtask

   task automatic test_timeout();
      int n;
      load(0, 5'd0, 16'h0008);
      load(0, 5'd1, 16'hFE00);
      exp_q.push_back(16'h0008);
      start_pulse(0);
      wait_run(0, found);
      pop_exp();
      tests++;
      if (!found || din1 !== exp_w) begin
         fails++;
         $display("FAIL to_run: found %b din %h expected %h",
                  found, din1, exp_w);
      end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (halted1 === 1'b1) break;
         if (busy1 === 1'b1) n++;
      end
      tests++;
      if (n != 15 || fault1 !== 1'b1 || halted1 !== 1'b1) begin
         fails++;
         $display("FAIL to_fault: waits %0d fault %b halted %b expected 15 1 1",
                  n, fault1, halted1);
      end
      start_pulse(0);
      tests++;
      if (fault1 !== 1'b0 || pc1 !== 5'd0 || busy1 !== 1'b1) begin
         fails++;
         $display("FAIL to_restart: fault %b pc %0d busy %b expected 0 0 1",
                  fault1, pc1, busy1);
      end
      exp_q.push_back(16'h0008);
      wait_run(0, found);
      pop_exp();
      pulse_done(0, 1);
      wait_halt(0, found);
      tests++;
      if (!found || fault1 !== 1'b0 || pc1 !== 5'd1) begin
         fails++;
         $display("FAIL to_rerun: found %b fault %b pc %0d expected 0 1",
                  found, fault1, pc1);
      end
   endtask

   task automatic test_wrap();
      load(1, 5'd3, 16'h0040);
      load(1, 5'd0, 16'h1234);
      load(1, 5'd1, 16'h0008);
      load(1, 5'd2, 16'h0008);
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h0040);
      start_pulse(1);
      for (int i = 0; i < 3; i++) begin
         wait_run(1, found);
         pop_exp();
         tests++;
         if (!found || din2 !== exp_w) begin
            fails++;
            $display("FAIL wrap_din%0d: found %b din %h expected %h",
                     i, found, din2, exp_w);
         end
         pulse_done(1, 1);
      end
      wait_run(1, found);
      pop_exp();
      tests++;
      if (!found || din2 !== exp_w || pc2 !== 2'd3) begin
         fails++;
         $display("FAIL wrap_mvi: found %b din %h pc %0d expected %h 3",
                  found, din2, pc2, exp_w);
      end
      @(negedge clk);
      tests++;
      if (din2 !== 16'h1234 || pc2 !== 2'd1) begin
         fails++;
         $display("FAIL wrap_imm: din %h pc %0d expected 1234 1", din2, pc2);
      end
      wait_halt(1, found);
      tests++;
      if (!found || fault2 !== 1'b1) begin
         fails++;
         $display("FAIL wrap_to: found %b fault %b expected 1 1",
                  found, fault2);
      end
   endtask

   task automatic test_busy_ignore();
      int r0;
      load(0, 5'd0, 16'h0008);
      load(0, 5'd1, 16'hFE00);
      exp_q.push_back(16'h0008);
      r0 = runs1;
      start_pulse(0);
      wait_run(0, found);
      pop_exp();
      tests++;
      if (!found || din1 !== exp_w) begin
         fails++;
         $display("FAIL bi_run: found %b din %h expected %h",
                  found, din1, exp_w);
      end
      @(negedge clk);
      load_en1 = 1'b1; load_addr1 = 5'd1; load_data1 = 16'h0081;
      start1 = 1'b1;
      @(negedge clk);
      load_en1 = 1'b0;
      start1 = 1'b0;
      tests++;
      if (pc1 !== 5'd1 || busy1 !== 1'b1 || run1 !== 1'b0) begin
         fails++;
         $display("FAIL bi_norestart: pc %0d busy %b run %b expected 1 1 0",
                  pc1, busy1, run1);
      end
      repeat (13) @(negedge clk);
      done1 = 1'b1;
      @(negedge clk);
      done1 = 1'b0;
      tests++;
      if (fault1 !== 1'b0 || busy1 !== 1'b1 || halted1 !== 1'b0) begin
         fails++;
         $display("FAIL bi_race: fault %b busy %b halted %b expected 0 1 0",
                  fault1, busy1, halted1);
      end
      @(negedge clk);
      tests++;
      if (halted1 !== 1'b1 || pc1 !== 5'd1 || runs1 - r0 != 1) begin
         fails++;
         $display("FAIL bi_mem: halted %b pc %0d runs %0d expected 1 1 1",
                  halted1, pc1, runs1 - r0);
      end
   endtask

   task automatic test_async_reset();
      load(0, 5'd0, 16'h0008);
      load(0, 5'd1, 16'h0081);
      load(0, 5'd2, 16'hFE00);
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h0081);
      start_pulse(0);
      wait_run(0, found);
      pop_exp();
      pulse_done(0, 1);
      wait_run(0, found);
      pop_exp();
      tests++;
      if (!found || din1 !== exp_w) begin
         fails++;
         $display("FAIL ar_pre: found %b din %h expected %h",
                  found, din1, exp_w);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({din1, run1, pc1, busy1, halted1, fault1} !== 25'd0) begin
         fails++;
         $display("FAIL ar_clear: got %h expected 0",
                  {din1, run1, pc1, busy1, halted1, fault1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h0081);
      start_pulse(0);
      wait_run(0, found);
      pop_exp();
      tests++;
      if (!found || din1 !== exp_w || pc1 !== 5'd0) begin
         fails++;
         $display("FAIL ar_restart: found %b din %h pc %0d expected %h 0",
                  found, din1, pc1, exp_w);
      end
      pulse_done(0, 1);
      wait_run(0, found);
      pop_exp();
      pulse_done(0, 1);
      wait_halt(0, found);
      tests++;
      if (!found || pc1 !== 5'd2 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL ar_end: found %b pc %0d left %0d expected 2 0",
                  found, pc1, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_start_load();
      test_mvi();
      test_sequence();
      test_timeout();
      test_wrap();
      test_busy_ignore();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
